// File: rtl/dekatron_driver.sv
// Sequencing front end for one dekatron counting stage: turns step/load commands
// into guide-pulse or Set strobes, waits for the tube to settle, reports digit and flags.
module dekatron_driver #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic       hsClk,
    input  logic       Rst_n,
    input  logic       Request,
    input  logic       Load,
    input  logic       Dir,
    input  logic [3:0] Steps,
    input  logic [9:0] LoadValue,
    input  logic [9:0] DekOut,
    input  logic       DekReady,
    output logic       PulseRight,
    output logic       PulseLeft,
    output logic       Set,
    output logic [9:0] In,
    output logic       Busy,
    output logic       Done,
    output logic [3:0] Value,
    output logic       Carry,
    output logic       Borrow,
    output logic       Error
);

    typedef enum logic [2:0] {IDLE, LOAD, PULSE, GAP, WAIT, FINISH} stateT;

    stateT       state;
    stateT       nextState;
    logic        loadQ;
    logic        dirQ;
    logic [3:0]  remaining;
    logic [9:0]  loadValQ;
    logic [3:0]  phaseCnt;
    logic [7:0]  waitCnt;
    logic        oneHot;
    logic [3:0]  decoded;
    logic        timeoutHit;
    logic        lastStep;

    assign oneHot     = (DekOut != 10'd0) && ((DekOut & (DekOut - 10'd1)) == 10'd0);
    assign timeoutHit = (waitCnt == 8'(TIMEOUT - 1));
    assign lastStep   = (remaining == 4'd1);

    always_comb begin
        decoded = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (DekOut[k]) decoded = 4'(k);
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (Request) begin
                    if (Load)               nextState = LOAD;
                    else if (Steps == 4'd0) nextState = FINISH;
                    else                    nextState = PULSE;
                end
            end
            LOAD:  nextState = WAIT;
            PULSE: if (phaseCnt == 4'(PULSE_CYCLES - 1)) nextState = GAP;
            GAP:   if (phaseCnt == 4'(GAP_CYCLES - 1))   nextState = WAIT;
            WAIT: begin
                if (DekReady) begin
                    if (!oneHot || loadQ || lastStep) nextState = FINISH;
                    else                              nextState = PULSE;
                end else if (timeoutHit) begin
                    nextState = FINISH;
                end
            end
            FINISH:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it is an ordinary branch inside the clocked block.
    always_ff @(posedge hsClk) begin
        if (!Rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Outputs are registered from the current state, so each lags its state by one cycle.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge hsClk) begin
        if (!Rst_n) begin
            loadQ      <= 1'b0;
            dirQ       <= 1'b0;
            remaining  <= 4'd0;
            loadValQ   <= 10'd0;
            phaseCnt   <= 4'd0;
            waitCnt    <= 8'd0;
            PulseRight <= 1'b0;
            PulseLeft  <= 1'b0;
            Set        <= 1'b0;
            In         <= 10'd0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Value      <= 4'd0;
            Carry      <= 1'b0;
            Borrow     <= 1'b0;
            Error      <= 1'b0;
        end else begin
            phaseCnt <= (nextState != state) ? 4'd0 : phaseCnt + 4'd1;

            if (state != WAIT || DekReady) waitCnt <= 8'd0;
            else                           waitCnt <= waitCnt + 8'd1;

            if (state == IDLE && Request) begin
                loadQ     <= Load;
                dirQ      <= Dir;
                remaining <= Steps;
                loadValQ  <= LoadValue;
                Carry     <= 1'b0;
                Borrow    <= 1'b0;
                Error     <= 1'b0;
            end

            if (state == WAIT) begin
                if (DekReady) begin
                    if (!oneHot) begin
                        Error <= 1'b1;
                    end else begin
                        Value <= decoded;
                        if (!loadQ) begin
                            if (!dirQ && Value == 4'd9 && decoded == 4'd0) Carry  <= 1'b1;
                            if (dirQ && Value == 4'd0 && decoded == 4'd9)  Borrow <= 1'b1;
                            remaining <= remaining - 4'd1;
                        end
                    end
                end else if (timeoutHit) begin
                    Error <= 1'b1;
                end
            end

            PulseRight <= (state == PULSE) && !dirQ;
            PulseLeft  <= (state == PULSE) && dirQ;
            Set        <= (state == LOAD);
            In         <= (state == LOAD) ? loadValQ : 10'd0;
            Busy       <= (state != IDLE) && (state != FINISH);
            Done       <= (state == FINISH);
        end
    end

endmodule

// File: tb/tb_dekatron_driver.sv
// Bench for dekatron_driver: a behavioural tube drives DekOut/DekReady, and expected
// digits, flags and latencies come from plain modulo-10 arithmetic on each command.
module tb_dekatron_driver;

    localparam int PC = 4;
    localparam int GC = 2;
    localparam int TO = 255;

    logic       hsClk;
    logic       Rst_n;
    logic       Request;
    logic       Load;
    logic       Dir;
    logic [3:0] Steps;
    logic [9:0] LoadValue;
    logic [9:0] DekOut;
    logic       DekReady;
    logic       PulseRight;
    logic       PulseLeft;
    logic       Set;
    logic [9:0] In;
    logic       Busy;
    logic       Done;
    logic [3:0] Value;
    logic       Carry;
    logic       Borrow;
    logic       Error;

    dekatron_driver #(.PULSE_CYCLES(PC), .GAP_CYCLES(GC), .TIMEOUT(TO)) dut (
        .hsClk(hsClk), .Rst_n(Rst_n), .Request(Request), .Load(Load), .Dir(Dir),
        .Steps(Steps), .LoadValue(LoadValue), .DekOut(DekOut), .DekReady(DekReady),
        .PulseRight(PulseRight), .PulseLeft(PulseLeft), .Set(Set), .In(In),
        .Busy(Busy), .Done(Done), .Value(Value), .Carry(Carry), .Borrow(Borrow),
        .Error(Error)
    );

    initial hsClk = 1'b0;
    always #5 hsClk = ~hsClk;

    int nTests = 0;
    int nFail  = 0;
    int curVal = 0;

    task automatic check(input string tag, input int got, input int exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural tube: a digit that moves one place per guide pulse or jumps on Set.
    logic [3:0] tubeDigit;
    logic       readyEn;
    logic       badOut;
    logic       prevR;
    logic       prevL;

    assign DekOut   = badOut ? 10'b0000000011 : (10'b1 << tubeDigit);
    assign DekReady = readyEn && !PulseRight && !PulseLeft;

    always @(negedge hsClk) begin
        if (Set) begin
            for (int k = 0; k < 10; k++) if (In[k]) tubeDigit <= 4'(k);
        end else if (PulseRight && !prevR) begin
            tubeDigit <= (tubeDigit == 4'd9) ? 4'd0 : tubeDigit + 4'd1;
        end else if (PulseLeft && !prevL) begin
            tubeDigit <= (tubeDigit == 4'd0) ? 4'd9 : tubeDigit - 4'd1;
        end
        prevR <= PulseRight;
        prevL <= PulseLeft;
    end

    task automatic junkRequest();
        Request   = 1'($urandom_range(0, 1));
        Load      = 1'($urandom_range(0, 1));
        Dir       = 1'($urandom_range(0, 1));
        Steps     = 4'($urandom_range(0, 15));
        LoadValue = 10'($urandom);
    endtask

    // Issues one command, watches every cycle until Done, then checks the outcome.
    task automatic runCmd(input logic ld, input logic dr, input logic [3:0] st,
                          input int dig, input string tag, input int expLat,
                          input int expVal, input int expC, input int expB,
                          input int expE, input int expPulses);
        int   lat = 0;
        int   rCnt = 0, lCnt = 0, setCnt = 0;
        int   badIn = 0, badOverlap = 0, badBusy = 0, badWidth = 0;
        int   runR = 0, runL = 0;
        bit   done = 0;
        logic pR = 1'b0, pL = 1'b0;
        logic [9:0] expIn;
        expIn = 10'b1 << dig;
        @(negedge hsClk);
        Request = 1'b1; Load = ld; Dir = dr; Steps = st; LoadValue = expIn;
        @(posedge hsClk);
        @(negedge hsClk);
        junkRequest();
        while (!done && lat < 400) begin
            @(posedge hsClk);
            lat++;
            @(negedge hsClk);
            if (PulseRight && !pR) rCnt++;
            if (PulseLeft && !pL)  lCnt++;
            pR = PulseRight;
            pL = PulseLeft;
            if (PulseRight) runR++;
            else if (runR > 0) begin if (runR != PC) badWidth++; runR = 0; end
            if (PulseLeft) runL++;
            else if (runL > 0) begin if (runL != PC) badWidth++; runL = 0; end
            if (Set) begin
                setCnt++;
                if (In != expIn) badIn++;
            end else if (In != 10'd0) badIn++;
            if ((PulseRight && PulseLeft) || (Set && (PulseRight || PulseLeft))) badOverlap++;
            if (Done) begin
                done = 1;
                Request = 1'b0;
                check({tag, " busy_at_done"}, int'(Busy), 0);
            end else begin
                if (!Busy) badBusy++;
                junkRequest();
            end
        end
        Request = 1'b0;
        check({tag, " done_seen"}, int'(done), 1);
        check({tag, " latency"}, lat, expLat);
        check({tag, " value"}, int'(Value), expVal);
        check({tag, " carry"}, int'(Carry), expC);
        check({tag, " borrow"}, int'(Borrow), expB);
        check({tag, " error"}, int'(Error), expE);
        check({tag, " pulses_dir"}, dr ? lCnt : rCnt, ld ? 0 : expPulses);
        check({tag, " pulses_other"}, dr ? rCnt : lCnt, 0);
        check({tag, " set_cycles"}, setCnt, ld ? 1 : 0);
        check({tag, " in_bus"}, badIn, 0);
        check({tag, " overlap"}, badOverlap, 0);
        check({tag, " busy_high"}, badBusy, 0);
        check({tag, " pulse_width"}, badWidth, 0);
        @(negedge hsClk);
        check({tag, " done_one_cycle"}, int'(Done), 0);
        curVal = expVal;
    endtask

    // Fault-free reference: the digit moves by Steps modulo 10 and any wrap sets the flag.
    task automatic refCmd(input logic ld, input logic dr, input logic [3:0] st,
                          input int dig, input string tag);
        int n;
        n = int'(st);
        if (ld)
            runCmd(1'b1, dr, st, dig, tag, 3, dig, 0, 0, 0, 0);
        else if (!dr)
            runCmd(1'b0, 1'b0, st, dig, tag, 1 + n * (PC + GC + 1), (curVal + n) % 10,
                   (curVal + n >= 10) ? 1 : 0, 0, 0, n);
        else
            runCmd(1'b0, 1'b1, st, dig, tag, 1 + n * (PC + GC + 1), ((curVal - n) % 10 + 10) % 10,
                   0, (curVal < n) ? 1 : 0, 0, n);
    endtask

    initial begin
        int doneCnt;
        Rst_n = 1'b0; Request = 1'b0; Load = 1'b0; Dir = 1'b0; Steps = 4'd0;
        LoadValue = 10'd0; readyEn = 1'b1; badOut = 1'b0; tubeDigit = 4'd5;
        prevR = 1'b0; prevL = 1'b0;
        repeat (3) @(posedge hsClk);
        @(negedge hsClk);
        check("reset pulses", int'({PulseRight, PulseLeft, Set}), 0);
        check("reset in", int'(In), 0);
        check("reset status", int'({Busy, Done, Carry, Borrow, Error}), 0);
        check("reset value", int'(Value), 0);
        Rst_n = 1'b1;

        refCmd(1'b1, 1'b0, 4'd0, 3, "load3");
        refCmd(1'b1, 1'b0, 4'd0, 7, "load7");
        refCmd(1'b0, 1'b0, 4'd4, 0, "up4_from7");
        check("up4 latency_formula", 1 + 4 * (PC + GC + 1), 29);
        refCmd(1'b1, 1'b0, 4'd0, 2, "load2");
        refCmd(1'b0, 1'b1, 4'd3, 0, "down3_from2");

        refCmd(1'b1, 1'b0, 4'd0, 4, "load4");
        readyEn = 1'b0;
        runCmd(1'b0, 1'b0, 4'd3, 0, "timeout", 1 + PC + GC + TO, 4, 0, 0, 1, 1);
        readyEn = 1'b1;

        refCmd(1'b1, 1'b0, 4'd0, 6, "load6");
        badOut = 1'b1;
        runCmd(1'b0, 1'b1, 4'd2, 0, "not_onehot", 1 + PC + GC + 1, 6, 0, 0, 1, 1);
        runCmd(1'b0, 1'b0, 4'd0, 0, "zero_steps", 1, 6, 0, 0, 0, 0);
        badOut = 1'b0;
        refCmd(1'b1, 1'b0, 4'd0, 0, "load0");

        @(negedge hsClk);
        Request = 1'b1; Load = 1'b0; Dir = 1'b0; Steps = 4'd5;
        @(posedge hsClk);
        @(negedge hsClk);
        Request = 1'b0;
        @(negedge hsClk);
        check("midpulse pulse_active", int'(PulseRight), 1);
        Rst_n = 1'b0;
        @(posedge hsClk);
        @(negedge hsClk);
        check("midreset pulse", int'(PulseRight), 0);
        check("midreset busy", int'(Busy), 0);
        check("midreset value", int'(Value), 0);
        Rst_n = 1'b1;
        doneCnt = 0;
        repeat (10) begin
            @(negedge hsClk);
            if (Done || Busy || PulseRight) doneCnt++;
        end
        check("midreset quiet", doneCnt, 0);
        curVal = 0;
        refCmd(1'b1, 1'b0, 4'd0, 8, "after_reset_load8");

        for (int i = 0; i < 40; i++) begin
            logic ld;
            ld = ($urandom_range(0, 3) == 0);
            refCmd(ld, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 9)), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/dekatron_driver.md
# dekatron_driver

Sequencing front end that drives a single dekatron counting stage through its PulseRight/PulseLeft/Set/In pins and reads back its Out/Ready pins. It accepts a step-or-load command from the arithmetic control, emits the required guide-pulse train one step at a time, waits for the tube to settle on a main cathode after each step, and reports the final digit, carry/borrow and fault status. One instance sits beside each dekatron in a register or counter column.

## Interface
- PULSE_CYCLES, 4: hsClk cycles each guide pulse is held high (1..15).
- GAP_CYCLES, 2: hsClk cycles both pulse lines are low after a pulse, before Ready is sampled (1..15).
- TIMEOUT, 255: maximum hsClk cycles spent waiting for DekReady per step or load (1..255).
- hsClk  in  1  system clock; all logic on its rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- Request  in  1  command strobe; accepted only when Busy=0.
- Load  in  1  sampled with Request: 1 = load LoadValue, 0 = step.
- Dir  in  1  sampled with Request: 0 = count up (PulseRight), 1 = count down (PulseLeft).
- Steps  in  4  sampled with Request: number of single-digit steps (0..15).
- LoadValue  in  10  one-hot digit to load; bit k = digit k.
- DekOut  in  10  tube main-cathode state, bit k = digit k.
- DekReady  in  1  tube settled on a main cathode, no pulse active.
- PulseRight  out  1  count-up guide pulse to tube.
- PulseLeft  out  1  count-down guide pulse to tube.
- Set  out  1  load strobe to tube.
- In  out  10  load value to tube; equals captured LoadValue while Set=1, else 0.
- Busy  out  1  command in progress.
- Done  out  1  one-cycle completion strobe.
- Value  out  4  binary digit decoded from last DekOut sample.
- Carry  out  1  valid with Done: an up-step wrapped 9->0.
- Borrow  out  1  valid with Done: a down-step wrapped 0->9.
- Error  out  1  valid with Done: timeout or non-one-hot DekOut.

## Operation
- States: IDLE, LOAD, PULSE, GAP, WAIT, FINISH.
- IDLE: Busy=0. On Request: capture Load, Dir, Steps, LoadValue; clear Carry/Borrow/Error. Load=1 -> LOAD. Load=0 and Steps=0 -> FINISH. Otherwise -> PULSE with remaining = Steps.
- LOAD: Set=1, In=captured LoadValue for exactly one cycle -> WAIT.
- PULSE: PulseRight (Dir=0) or PulseLeft (Dir=1) high for PULSE_CYCLES cycles; never both -> GAP.
- GAP: both pulses low for GAP_CYCLES cycles -> WAIT, timeout counter cleared.
- WAIT: each cycle, if DekReady=1: sample DekOut. Non-one-hot (zero or >1 bit) -> Error=1, FINISH. Else update Value; for a step, set Carry if previous Value=9 and new=0 with Dir=0, set Borrow if previous=0 and new=9 with Dir=1; decrement remaining; remaining=0 or load -> FINISH, else -> PULSE. If DekReady=0 for TIMEOUT consecutive cycles -> Error=1, FINISH (remaining steps abandoned).
- FINISH: Done=1 one cycle, Busy=0 in same cycle -> IDLE.
- Carry/Borrow are sticky for the command; hold until next accepted Request.
- Requests while Busy=1 are ignored (not queued).
- Value tracks the tube only at WAIT samples; pre-load Value for carry comparison is the last sampled Value.

## Timing
- Reset (Rst_n=0 at an edge): state IDLE; PulseRight, PulseLeft, Set, In, Busy, Done, Carry, Borrow, Error = 0; Value = 0. Reset mid-command drops any active pulse on the next edge; no Done issued.
- All outputs registered. Busy rises the cycle after Request accepted.
- Step latency with tube Ready immediately after GAP: 1 + Steps*(PULSE_CYCLES+GAP_CYCLES+1) cycles from accepting edge to Done; defaults: 1+7*Steps.
- Load latency with immediate Ready: 3 cycles (LOAD, WAIT, FINISH).
- Steps=0: Done 1 cycle after accept, no pulses, flags 0.
- Set never overlaps a pulse; pulse lines change only at PULSE/GAP boundaries.

## Test plan
- Reset, load LoadValue=0000001000 (digit 3) -> one Set cycle with In=0000001000, Done after 3 cycles, Value=3, Error=0.
- From digit 7, Dir=0 Steps=4 -> four PulseRight bursts of 4 cycles each, Done at cycle 29, Value=1, Carry=1, Borrow=0.
- From digit 2, Dir=1 Steps=3 -> three PulseLeft bursts, Value=9, Borrow=1, Carry=0.
- Hold DekReady=0 after first pulse -> Done after GAP+255 wait cycles, Error=1, no further pulses.
- DekOut=0000000011 at sample -> Error=1, Value unchanged; Steps=0 request -> Done next cycle, no pulse.
- Assert Rst_n=0 mid-PULSE -> PulseRight=0, Busy=0 next cycle, no Done; new Request accepted afterwards.
